// File: rtl/uart_tx_pkg.sv
// Shared UART definitions: FSM state encodings, parity codes and the bit-period
// formula, common to the transmitter and receiver.
package uart_tx_pkg;

    typedef logic [2:0] uart_state_t;

    localparam uart_state_t ST_IDLE   = 3'd0;
    localparam uart_state_t ST_START  = 3'd1;
    localparam uart_state_t ST_DATA   = 3'd2;
    localparam uart_state_t ST_PARITY = 3'd3;
    localparam uart_state_t ST_STOP   = 3'd4;

    localparam int UART_PARITY_NONE = 0;
    localparam int UART_PARITY_EVEN = 1;
    localparam int UART_PARITY_ODD  = 2;

    // Clock cycles per bit, rounded to nearest.
    function automatic int bit_cycles(input int clk_freq, input int baud_rate);
        return (clk_freq + baud_rate / 2) / baud_rate;
    endfunction

    function automatic logic parity_bit(input logic [7:0] data, input int mode);
        return (mode == UART_PARITY_ODD) ? ~^data : ^data;
    endfunction

endpackage

// File: rtl/uart_tx_baud_tick.sv
// Bit-period timer: pulses tick once every BIT_CYCLES enabled cycles and
// restarts from PRELOAD on start (the receiver uses a half-period preload).
module uart_tx_baud_tick #(
    parameter int BIT_CYCLES = 1302,
    parameter int PRELOAD    = 0,
    localparam int CW        = (BIT_CYCLES > 1) ? $clog2(BIT_CYCLES) : 1
) (
    input  logic clk,
    input  logic reset_n,
    input  logic enable,
    input  logic start,
    output logic tick
);

    localparam logic [CW-1:0] LAST      = CW'(BIT_CYCLES - 1);
    localparam logic [CW-1:0] START_VAL = CW'(PRELOAD);

    logic [CW-1:0] cnt;

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            cnt <= '0;
        end else if (start) begin
            cnt <= START_VAL;
        end else if (enable) begin
            cnt <= (cnt == LAST) ? '0 : cnt + 1'b1;
        end
    end

    assign tick = enable && (cnt == LAST);

endmodule

// File: rtl/uart_tx.sv
// UART transmitter: one-byte holding buffer feeding an 8N1/8E/8O framer with
// 1 or 2 stop bits; a buffered byte follows the previous frame with no gap.
//
//  state     | meaning
//  ST_IDLE   | line idle, waiting for a buffered byte
//  ST_START  | start bit (0)
//  ST_DATA   | d0..d7, LSB first
//  ST_PARITY | optional parity bit
//  ST_STOP   | STOP_BITS stop bits (1); may chain straight into ST_START
module uart_tx
    import uart_tx_pkg::*;
#(
    parameter int CLK_FREQ  = 50_000_000,
    parameter int BAUD_RATE = 38400,
    parameter int PARITY    = 0,
    parameter int STOP_BITS = 1
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic [7:0] tx_data,
    input  logic       tx_valid,
    output logic       tx_ready,
    output logic       tx,
    output logic       busy
);

    localparam int          BIT_CYCLES = bit_cycles(CLK_FREQ, BAUD_RATE);
    localparam logic [2:0]  STOP_LAST  = 3'(STOP_BITS - 1);

    uart_state_t state;
    logic [7:0]  hold_data;
    logic        hold_valid;
    logic [7:0]  shifter;
    logic        par_bit;
    logic [2:0]  bit_cnt;
    logic        tick;
    logic        accept;
    logic        stop_done;
    logic        load;

    assign tx_ready  = ~hold_valid;
    assign busy      = (state != ST_IDLE) | hold_valid;
    assign accept    = tx_valid & ~hold_valid;
    assign stop_done = (state == ST_STOP) && tick && (bit_cnt == STOP_LAST);
    assign load      = hold_valid && ((state == ST_IDLE) || stop_done);

    uart_tx_baud_tick #(
        .BIT_CYCLES (BIT_CYCLES),
        .PRELOAD    (0)
    ) u_baud (
        .clk     (clk),
        .reset_n (reset_n),
        .enable  (state != ST_IDLE),
        .start   (load),
        .tick    (tick)
    );

    // Accept and consume are mutually exclusive: accept needs an empty buffer.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            hold_valid <= 1'b0;
            hold_data  <= '0;
        end else if (accept) begin
            hold_valid <= 1'b1;
            hold_data  <= tx_data;
        end else if (load) begin
            hold_valid <= 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state   <= ST_IDLE;
            shifter <= '0;
            par_bit <= 1'b0;
            bit_cnt <= '0;
        end else begin
            if (load) begin
                shifter <= hold_data;
                par_bit <= parity_bit(hold_data, PARITY);
            end
            case (state)
                ST_IDLE: begin
                    bit_cnt <= '0;
                    if (load) state <= ST_START;
                end
                ST_START: begin
                    if (tick) begin
                        state   <= ST_DATA;
                        bit_cnt <= '0;
                    end
                end
                ST_DATA: begin
                    if (tick) begin
                        shifter <= {1'b0, shifter[7:1]};
                        if (bit_cnt == 3'd7) begin
                            bit_cnt <= '0;
                            state   <= (PARITY != UART_PARITY_NONE) ? ST_PARITY : ST_STOP;
                        end else begin
                            bit_cnt <= bit_cnt + 3'd1;
                        end
                    end
                end
                ST_PARITY: begin
                    if (tick) begin
                        state   <= ST_STOP;
                        bit_cnt <= '0;
                    end
                end
                ST_STOP: begin
                    if (tick) begin
                        if (bit_cnt == STOP_LAST) begin
                            bit_cnt <= '0;
                            state   <= load ? ST_START : ST_IDLE;
                        end else begin
                            bit_cnt <= bit_cnt + 3'd1;
                        end
                    end
                end
                default: begin
                    state   <= ST_IDLE;
                    bit_cnt <= '0;
                end
            endcase
        end
    end

    // Line is registered from the current state, so it trails the FSM by one cycle.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            tx <= 1'b1;
        end else begin
            case (state)
                ST_START:  tx <= 1'b0;
                ST_DATA:   tx <= shifter[0];
                ST_PARITY: tx <= par_bit;
                default:   tx <= 1'b1;
            endcase
        end
    end

endmodule

// File: doc/uart_tx.md
# uart_tx

UART transmitter, the outbound counterpart of the synth's UART receive path on PMOD4. It serialises bytes from a valid/ready stream into 8-bit, LSB-first frames with optional parity. It holds one byte in a buffer so that back-to-back frames go out with no idle gap. It drives the debug/host link from `top` (the MIDI/host echo and status reporting path) at the same baud rate as the receiver.

## Interface
- `CLK_FREQ`, 50_000_000: clock frequency in Hz.
- `BAUD_RATE`, 38400: line rate in bit/s.
- `PARITY`, 0: 0 = none, 1 = even, 2 = odd.
- `STOP_BITS`, 1: 1 or 2.
- `clk` in 1: system clock, one clock domain.
- `reset_n` in 1: synchronous, active-low reset.
- `tx_data` in 8: byte to send.
- `tx_valid` in 1: `tx_data` is valid.
- `tx_ready` out 1: the holding buffer is empty. A byte is accepted when `tx_valid && tx_ready` at a rising edge.
- `tx` out 1: serial line, idle high.
- `busy` out 1: a frame is on the line or a byte is buffered.

## Operation
- `BIT_CYCLES = (CLK_FREQ + BAUD_RATE/2) / BAUD_RATE`, rounded to nearest. At the defaults this is 1302. Counter width is `$clog2(BIT_CYCLES)`.
- Frame: start (0), d0..d7, optional parity bit, then `STOP_BITS` stop bits (1).
  - Even parity bit = `^data`.
  - Odd parity bit = `~^data`.
- Holding buffer: `hold_data` and `hold_valid`.
  - `tx_ready = ~hold_valid` (combinational from the register).
  - On accept, `hold_valid` is set on the next edge.
- FSM states: IDLE, START, DATA, PARITY, STOP.
  - IDLE, with `hold_valid`: load the shifter from `hold_data`, clear `hold_valid`, go to START.
  - START: after BIT_CYCLES, go to DATA.
  - DATA: 8 bits, shifting right; `tx = shifter[0]`. After the 8th bit, go to PARITY if `PARITY != 0`, else STOP.
  - PARITY: after BIT_CYCLES, go to STOP.
  - STOP: lasts `STOP_BITS * BIT_CYCLES` cycles. On its last cycle:
    - if `hold_valid`, load the shifter, clear `hold_valid`, go to START (no idle gap);
    - else go to IDLE.
- `tx` is registered and driven from the state/shifter. IDLE and STOP drive 1.
- `busy = (state != IDLE) | hold_valid`.
- A byte can be accepted while a frame is in progress. Only one byte is buffered.
- Accept and consume never coincide, because accept requires `hold_valid = 0`.
- `tx_data` is only sampled at accept. Later changes have no effect.

## Timing
- Reset (`reset_n = 0` at an edge) gives, on the next cycle:
  - state IDLE
  - `tx = 1`
  - `tx_ready = 1`
  - `busy = 0`
  - `hold_valid = 0`
  - bit and baud counters at 0
- Reset mid-frame aborts the frame immediately (the line returns high) and discards the buffered byte.
- Latency: byte accepted at edge N (idle) → `hold_valid` at N+1 → FSM loads at N+1 → `tx` falls at edge N+2.
- Every bit, including each stop bit, is exactly BIT_CYCLES cycles. There is no drift across bits or frames.
- Frame length is `(10 + (PARITY != 0) + (STOP_BITS - 1)) * BIT_CYCLES` cycles.
- Back-to-back: the next start bit begins on the cycle after the last stop-bit cycle.
- `tx_ready` returns high one cycle after the FSM consumes the buffer.

## Structure
- Shared include `uart_defs.vh`, used with `globals.vh`:
  - state encodings;
  - parity codes (`UART_PARITY_NONE`, `UART_PARITY_EVEN`, `UART_PARITY_ODD`);
  - the `BIT_CYCLES` formula macro, also used by the receiver.
- Sub-module `uart_baud_tick`:
  - enable-gated counter that pulses `tick` every BIT_CYCLES cycles;
  - restarts to 0 on `start` (FSM load).
  - The receiver can reuse it with a half-period preload.
- `uart_tx` contains the buffer, FSM, shifter and bit counter. Estimated 150–250 lines.

## Test plan
- Sim parameters: `CLK_FREQ = 1_000_000`, `BAUD_RATE = 100_000`, so BIT_CYCLES = 10.
- Send 0x55, no parity, 1 stop bit. Required on `tx`:
  - falls 2 cycles after accept;
  - bit sequence 0,1,0,1,0,1,0,1,0,1, each bit 10 cycles;
  - `busy` drops when the frame ends.
- Hold `tx_valid` high with 0xA3 then 0x0F. Required:
  - the second byte is accepted during the first frame;
  - the second start bit begins exactly 100 cycles after the first;
  - no idle cycles between frames;
  - `tx_ready` stays low until the first frame has ended and the buffered byte has been loaded.
- `PARITY = 1`, `STOP_BITS = 2`, send 0x07. Required:
  - parity bit = 1;
  - frame = 120 cycles;
  - `tx` high for 20 cycles of stop bits.
- `PARITY = 2`, send 0x00. Required: parity bit = 1 (odd).
- Assert `reset_n = 0` at cycle 35 of a frame with a byte buffered. Required on the next cycle:
  - `tx = 1`, `tx_ready = 1`, `busy = 0`;
  - no further frame after reset is released.
- Default parameters, send 0x00. Required: start bit measured as exactly 1302 cycles.
